// File: rtl/deserializer_if.sv
// deserializer_if
//   Groups the serial-side and word-side handshake signals of the
//   deserializer into one bundle.
//
//   Serial side : i_en, i_din, i_din_valid (towards the deserializer),
//                 o_ready (back to the serial source).
//   Word side   : ov_dout, o_dout_valid (towards downstream),
//                 i_ready (back from downstream).
//   Status      : ov_bit_count, bits collected in the current partial word.
//
//   Modports:
//     slave  - the deserializer itself.
//     master - whoever drives the serial stream and consumes the words.
//
//   LENGTH must match the LENGTH of the deserializer it is connected to.
interface deserializer_if #(
  parameter int LENGTH = 24
);
  localparam int CNT_BITS = $clog2(LENGTH);

  logic                i_en;
  logic                i_din;
  logic                i_din_valid;
  logic                o_ready;
  logic [LENGTH-1:0]   ov_dout;
  logic                o_dout_valid;
  logic                i_ready;
  logic [CNT_BITS-1:0] ov_bit_count;

  modport slave (
    input  i_en,
    input  i_din,
    input  i_din_valid,
    input  i_ready,
    output o_ready,
    output ov_dout,
    output o_dout_valid,
    output ov_bit_count
  );

  modport master (
    output i_en,
    output i_din,
    output i_din_valid,
    output i_ready,
    input  o_ready,
    input  ov_dout,
    input  o_dout_valid,
    input  ov_bit_count
  );
endinterface

// File: rtl/deserializer.sv
// deserializer
//   Receive-side counterpart of the serializer in the FIR filter datapath.
//   Collects a serial bit stream, LSB first, into LENGTH-bit words and
//   hands each word downstream through a single output holding register
//   with a valid/ready handshake.
//
//   Ports:
//     i_clk    - rising-edge clock.
//     i_rst_n  - asynchronous active-low reset; clears all state.
//     bus      - deserializer_if.slave:
//                i_en / i_din / i_din_valid / o_ready : serial input side,
//                ov_dout / o_dout_valid / i_ready     : word output side,
//                ov_bit_count                         : partial-word count.
//
//   The bits of the next word may be collected while the previous word
//   still waits in the holding register; only the final bit of a word is
//   held off (o_ready low) until the holding register has been emptied.
module deserializer #(
  parameter int LENGTH = 24
) (
  input logic           i_clk,
  input logic           i_rst_n,
  deserializer_if.slave bus
);

  localparam int                  CNT_BITS = $clog2(LENGTH);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(LENGTH - 1);

  logic [LENGTH-1:0]   shift_q;
  logic [LENGTH-1:0]   shift_d;
  logic [LENGTH-1:0]   dout_q;
  logic [LENGTH-1:0]   dout_d;
  logic                dout_valid_q;
  logic                dout_valid_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  logic                last_bit;
  logic                ready;
  logic                acc;
  logic [LENGTH-1:0]   shifted;

  // Ready depends on state only, so the serial source never sees a
  // combinational path from the downstream i_ready.
  always_comb begin
    last_bit = (cnt_q == LAST_IDX);
    ready    = ~(last_bit & dout_valid_q);
    acc      = bus.i_en & bus.i_din_valid & ready;
    // New bit enters at the top; after LENGTH shifts bit k sits at index k.
    shifted  = {bus.i_din, shift_q[LENGTH-1:1]};
  end

  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (dout_valid_q && bus.i_ready) begin
      dout_valid_d = 1'b0;
    end

    if (acc) begin
      shift_d = shifted;
      if (last_bit) begin
        // Completion only happens with an empty holding register (ready
        // blocks it otherwise), so this never overwrites a pending word.
        cnt_d        = '0;
        dout_d       = shifted;
        dout_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.ov_dout      = dout_q;
  assign bus.o_dout_valid = dout_valid_q;
  assign bus.ov_bit_count = cnt_q;

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer
//   Self-checking bench for the deserializer. A word-level model (bit
//   index counter, partial word built by indexed bit insertion, one
//   pending-word slot) is compared against the DUT every cycle, a
//   scoreboard checks every word consumed downstream against the words the
//   stimulus sent, and directed scenarios pin literal values.
module tb_deserializer;

  localparam int LENGTH = 24;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  deserializer_if #(.LENGTH(LENGTH)) bus ();

  deserializer #(.LENGTH(LENGTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Word-level model state.
  int                m_bits    = 0;
  logic [LENGTH-1:0] m_partial = '0;
  logic [LENGTH-1:0] m_word    = '0;
  bit                m_pend    = 1'b0;
  logic              m_ready;

  // Scoreboard and monitors.
  logic [LENGTH-1:0] exp_q[$];
  int                cons_times[$];
  int                cons_count    = 0;
  bit                monitor_ready = 1'b0;
  bit                ready_dropped = 1'b0;

  logic [LENGTH-1:0] word_b;

  // Only the final bit of a word may be refused, and only while a word
  // still waits downstream.
  assign m_ready = !((m_bits == LENGTH - 1) && m_pend);

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit dv, input bit din,
                               input bit rdy);
    bus.i_en        = en;
    bus.i_din_valid = dv;
    bus.i_din       = din;
    bus.i_ready     = rdy;
  endtask

  // Model update on each clock edge, from the inputs present at that edge.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_bits    = 0;
      m_partial = '0;
      m_word    = '0;
      m_pend    = 1'b0;
    end else begin
      if (bus.i_en && bus.i_din_valid && m_ready) begin
        if (m_pend && bus.i_ready) m_pend = 1'b0;
        m_partial[m_bits] = bus.i_din;
        m_bits++;
        if (m_bits == LENGTH) begin
          m_word    = m_partial;
          m_pend    = 1'b1;
          m_bits    = 0;
          m_partial = '0;
        end
      end else if (m_pend && bus.i_ready) begin
        m_pend = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model plus downstream scoreboard.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      checkOutput("o_ready", 32'(bus.o_ready), 32'(m_ready));
      checkOutput("o_dout_valid", 32'(bus.o_dout_valid), 32'(m_pend));
      checkOutput("ov_bit_count", 32'(bus.ov_bit_count), 32'(m_bits));
      if (m_pend) checkOutput("ov_dout", 32'(bus.ov_dout), 32'(m_word));
      if (bus.o_dout_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sb_word: got 0x%0h, required no word", bus.ov_dout);
        end else begin
          checkOutput("sb_word", 32'(bus.ov_dout), 32'(exp_q.pop_front()));
        end
        cons_times.push_back(cyc);
        cons_count++;
      end
      if (monitor_ready && !bus.o_ready) ready_dropped = 1'b1;
    end
  end

  // Drives bits lo..hi of w, one accepted bit per step; with gaps the
  // enable and valid are randomly dropped. Returns at one time unit after
  // the edge that accepted bit hi.
  task automatic sendBits(input logic [LENGTH-1:0] w, input int lo,
                          input int hi, input bit gaps);
    for (int k = lo; k <= hi; k++) begin
      bit took;
      int tries;
      took  = 1'b0;
      tries = 0;
      while (!took) begin
        if (gaps)
          applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                        w[k], bus.i_ready);
        else
          applyStimulus(1'b1, 1'b1, w[k], bus.i_ready);
        @(negedge i_clk);
        took = bus.i_en && bus.i_din_valid && bus.o_ready;
        @(posedge i_clk);
        #1;
        tries++;
        if (!took && tries > 200) begin
          total++;
          bad++;
          $display("[TB] FAIL bit_accept_timeout: got no accept of bit %0d, required accept within 200 cycles", k);
          return;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b1, 1'b0, 1'b0, bus.i_ready);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_dout", 32'(bus.ov_dout), 32'h0);
    checkOutput("reset_valid", 32'(bus.o_dout_valid), 32'h0);
    checkOutput("reset_count", 32'(bus.ov_bit_count), 32'h0);
    checkOutput("reset_ready", 32'(bus.o_ready), 32'h1);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Single word, downstream always ready.
    $display("[TB] single word 0xA5C3F1");
    exp_q.push_back(24'hA5C3F1);
    sendBits(24'hA5C3F1, 0, 23, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("w1_valid", 32'(bus.o_dout_valid), 32'h1);
    checkOutput("w1_dout", 32'(bus.ov_dout), 32'hA5C3F1);
    checkOutput("w1_count", 32'(bus.ov_bit_count), 32'h0);
    @(posedge i_clk);
    #1;
    checkOutput("w1_pulse_end", 32'(bus.o_dout_valid), 32'h0);
    idle(1);

    // Back-to-back words.
    $display("[TB] back-to-back 0x000001, 0x800000");
    monitor_ready = 1'b1;
    exp_q.push_back(24'h000001);
    exp_q.push_back(24'h800000);
    sendBits(24'h000001, 0, 23, 1'b0);
    checkOutput("b2b_first", 32'(bus.ov_dout), 32'h000001);
    sendBits(24'h800000, 0, 23, 1'b0);
    checkOutput("b2b_second", 32'(bus.ov_dout), 32'h800000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    monitor_ready = 1'b0;
    idle(2);
    checkOutput("b2b_ready_dropped", 32'(ready_dropped), 32'h0);
    checkOutput("b2b_spacing",
                32'(cons_times[cons_times.size()-1] - cons_times[cons_times.size()-2]),
                32'd24);

    // Backpressure through two words.
    $display("[TB] backpressure 0x123456, 0x654321");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'h654321);
    sendBits(24'h123456, 0, 23, 1'b0);
    word_b = 24'h654321;
    sendBits(word_b, 0, 22, 1'b0);
    applyStimulus(1'b1, 1'b1, word_b[23], 1'b0);
    repeat (3) begin
      @(posedge i_clk);
      #1;
      checkOutput("bp_ready_low", 32'(bus.o_ready), 32'h0);
      checkOutput("bp_count", 32'(bus.ov_bit_count), 32'd23);
      checkOutput("bp_hold_dout", 32'(bus.ov_dout), 32'h123456);
      checkOutput("bp_hold_valid", 32'(bus.o_dout_valid), 32'h1);
    end
    applyStimulus(1'b1, 1'b1, word_b[23], 1'b1);
    @(posedge i_clk);
    #1;
    checkOutput("bp_consumed_valid", 32'(bus.o_dout_valid), 32'h0);
    checkOutput("bp_still_23", 32'(bus.ov_bit_count), 32'd23);
    checkOutput("bp_ready_back", 32'(bus.o_ready), 32'h1);
    @(posedge i_clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_second_valid", 32'(bus.o_dout_valid), 32'h1);
    checkOutput("bp_second_dout", 32'(bus.ov_dout), 32'h654321);
    checkOutput("bp_second_count", 32'(bus.ov_bit_count), 32'h0);
    idle(2);

    // Random gaps on enable and valid.
    $display("[TB] gaps 0x5A5A5A");
    exp_q.push_back(24'h5A5A5A);
    sendBits(24'h5A5A5A, 0, 23, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("gap_valid", 32'(bus.o_dout_valid), 32'h1);
    checkOutput("gap_dout", 32'(bus.ov_dout), 32'h5A5A5A);
    idle(2);

    // Asynchronous reset in the middle of a word.
    $display("[TB] async reset mid-word");
    word_b = 24'h0003FF;
    sendBits(word_b, 0, 9, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_reset_count", 32'(bus.ov_bit_count), 32'd10);
    #3 i_rst_n = 1'b0;
    #1;
    checkOutput("ar_count", 32'(bus.ov_bit_count), 32'h0);
    checkOutput("ar_valid", 32'(bus.o_dout_valid), 32'h0);
    checkOutput("ar_dout", 32'(bus.ov_dout), 32'h0);
    checkOutput("ar_ready", 32'(bus.o_ready), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("ar_held_count", 32'(bus.ov_bit_count), 32'h0);
    #2 i_rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge i_clk);
    #1;
    exp_q.push_back(24'h0F0F0F);
    sendBits(24'h0F0F0F, 0, 23, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ar_word_valid", 32'(bus.o_dout_valid), 32'h1);
    checkOutput("ar_word_dout", 32'(bus.ov_dout), 32'h0F0F0F);
    idle(2);

    // Pending word drained while serial side is disabled.
    $display("[TB] drain with enable low");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(24'h3C3C3C);
    sendBits(24'h3C3C3C, 0, 23, 1'b0);
    word_b = 24'h00001F;
    sendBits(word_b, 0, 4, 1'b0);
    checkOutput("en_pre_count", 32'(bus.ov_bit_count), 32'd5);
    checkOutput("en_pre_valid", 32'(bus.o_dout_valid), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge i_clk);
    #1;
    checkOutput("en_drained_valid", 32'(bus.o_dout_valid), 32'h0);
    checkOutput("en_frozen_count", 32'(bus.ov_bit_count), 32'd5);
    @(posedge i_clk);
    #1;
    checkOutput("en_frozen_count2", 32'(bus.ov_bit_count), 32'd5);
    exp_q.push_back(24'h00001F);
    sendBits(word_b, 5, 23, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("en_resume_dout", 32'(bus.ov_dout), 32'h00001F);
    idle(3);

    checkOutput("words_consumed", 32'(cons_count), 32'd9);
    checkOutput("sb_leftover", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's serializer in the FIR filter datapath.
- Collects a serial bit stream, LSB first, into LENGTH-bit parallel words.
- Presents each word downstream over a valid/ready handshake, with one output holding register.
- Exerts backpressure on the serial source when the output register cannot accept a completed word.

Parameters:
- LENGTH, 24, word width in bits (>= 2).
- Internal: CNT_BITS = $clog2(LENGTH), bit counter width (derived, not overridable).

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  enable for serial-side acceptance; output handshake ignores it.
- i_din  in  1  serial data bit, LSB of word first.
- i_din_valid  in  1  i_din carries a valid bit this cycle.
- o_ready  out  1  deserializer can accept a bit this cycle.
- ov_dout  out  LENGTH  assembled word (output holding register).
- o_dout_valid  out  1  ov_dout holds an unconsumed word.
- i_ready  in  1  downstream accepts ov_dout this cycle.
- ov_bit_count  out  CNT_BITS  bits collected in current partial word (status).

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - shift register, ov_dout and bit counter cleared to 0.
  - o_dout_valid = 0.
  - All state is held while reset is asserted.
  - Any partial word is discarded; the first bit after release is bit 0 of a new word.
- Bit accept: acc = i_en & i_din_valid & o_ready.
  - On acc, shift register <= {i_din, shift[LENGTH-1:1]}, so bit k ends at position k after LENGTH accepts.
  - Counter increments on acc.
  - No acc: shift register and counter hold.
- Word complete: acc while counter == LENGTH-1.
  - Same edge: ov_dout <= {i_din, shift[LENGTH-1:1]}, o_dout_valid <= 1, counter <= 0.
  - Shift register contents after completion are don't-care; they are fully overwritten by the next word.
- Latency: word visible on ov_dout with o_dout_valid = 1 on the cycle after its last bit is accepted.
- o_ready (combinational from state only, never from i_ready) = ~(counter == LENGTH-1 & o_dout_valid).
  - Effect: the last bit of a word stalls until the holding register is empty.
- Output handshake:
  - Word consumed on the edge where o_dout_valid & i_ready.
  - o_dout_valid clears unless a word completes on the same edge. Completion cannot coincide with a pending word because o_ready blocks it, so there is no overwrite.
  - While o_dout_valid = 1 and i_ready = 0, ov_dout and o_dout_valid are held stable.
- Bits 0..LENGTH-2 of the next word may be accepted while the previous word waits downstream (overlap).
- Throughput: one word per LENGTH accepted bits when i_ready is held high.
- i_en low:
  - no bit acceptance; counter and shift register frozen.
  - output handshake still completes normally.
- ov_bit_count = counter, range 0..LENGTH-1, never reaches LENGTH.
- i_din is ignored when i_din_valid = 0 or o_ready = 0.

Test Plan:
- Reset then 24 consecutive valid bits of 0xA5C3F1, LSB first, with i_ready = 1 -> o_dout_valid pulses for one cycle, one cycle after the 24th bit; ov_dout = 0xA5C3F1; ov_bit_count returns to 0.
- Back-to-back words 0x000001 then 0x800000, i_ready = 1 -> two valid pulses 24 cycles apart with the correct values; o_ready never drops.
- Backpressure: i_ready = 0 through two full words (0x123456, 0x654321) ->
  - first word held stable on ov_dout;
  - o_ready = 0 once ov_bit_count = 23;
  - raising i_ready consumes 0x123456, then the next edge accepts the stalled last bit, and 0x654321 appears the following cycle.
- Gaps: i_din_valid and i_en toggled randomly while sending 0x5A5A5A -> ov_dout = 0x5A5A5A; bit count frozen during gaps.
- Async reset asserted mid-word (after 10 bits) and between clock edges -> outputs clear immediately; the next 24 bits 0x0F0F0F produce exactly 0x0F0F0F.
- Pending word, then i_en = 0 and i_ready = 1 -> word consumed and o_dout_valid = 0; ov_bit_count unchanged.
